// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu (package)
// Description : Shared display resolution defaults, pixel type, scanout FSM
//               state encoding and framebuffer address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu;

    localparam int H_RESOLUTION = 320;
    localparam int V_RESOLUTION = 240;

    typedef logic [15:0] pixel_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Byte offset of a halfword pixel: {row, col, 0}, zero-extended to 32 bits.
    function automatic logic [31:0] pixel_offset(input logic [7:0] row,
                                                 input logic [8:0] col);
        return {14'd0, row, col, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scanout_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scanout_fifo
// Description : Synchronous show-ahead pixel FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_fifo
    import gpu::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  pixel_t        i_push_data,
    input  logic          i_pop,
    output logic          o_empty,
    output pixel_t        o_head,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] c_FULL = (AW + 1)'(DEPTH);

    pixel_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; consumers only look at it while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pixel_scanout.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scanout
// Description : Fetches one frame over Avalon-MM with credit-based flow control
//               and streams it out with start-of-frame / end-of-line tags.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scanout
    import gpu::*;
#(
    parameter int H_RES      = H_RESOLUTION,
    parameter int V_RES      = V_RESOLUTION,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic [15:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [8:0]      c_COL_LAST = 9'(H_RES - 1);
    localparam logic [7:0]      c_ROW_LAST = 8'(V_RES - 1);
    localparam logic [c_AW+1:0] c_CREDITS  = (c_AW + 2)'(FIFO_DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [31:0]   r_base;
    logic [7:0]    r_row;
    logic [8:0]    r_col;
    logic [7:0]    r_out_row;
    logic [8:0]    r_out_col;
    logic [c_AW:0] r_outstanding;
    logic          r_last_out;

    logic [c_AW:0] w_fifo_count;
    logic          w_fifo_empty;
    pixel_t        w_fifo_head;
    logic          w_credit_ok;
    logic          w_accept;
    logic          w_resp;
    logic          w_pop;
    logic          w_last_read;
    logic          w_last_pix;
    logic          w_drained;
    logic          w_start_ok;

    // Reads in flight plus buffered pixels may never exceed the FIFO size.
    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < c_CREDITS;
    assign w_accept    = m_read && !m_waitrequest;
    assign w_resp      = m_readdatavalid && (r_outstanding != '0);
    assign w_pop       = pix_valid && pix_ready;
    assign w_last_read = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_last_pix  = w_pop && (r_out_row == c_ROW_LAST) && (r_out_col == c_COL_LAST);
    assign w_drained   = (r_outstanding == '0) && w_fifo_empty && r_last_out;
    assign w_start_ok  = (r_state == c_ST_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        m_read       = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                m_read = w_credit_ok;
                if (w_credit_ok && !m_waitrequest && w_last_read)
                    w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_drained) begin
                    frame_done   = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign m_address = (r_state == c_ST_FETCH) ? (r_base + pixel_offset(r_row, r_col)) : '0;

    // Fetch-side position; base is captured only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_start_ok) begin
            r_base <= base_addr;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_accept) begin
            if (w_last_read) begin
                r_row <= '0;
                r_col <= '0;
            end else if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_resp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Output-side position drives the sof/eol tags and end-of-frame detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_last_out <= 1'b0;
        end else if (w_start_ok) begin
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_last_out <= 1'b0;
        end else if (frame_done) begin
            r_last_out <= 1'b0;
        end else if (w_pop) begin
            if (r_out_col == c_COL_LAST) begin
                r_out_col <= '0;
                r_out_row <= (r_out_row == c_ROW_LAST) ? '0 : r_out_row + 1'b1;
            end else begin
                r_out_col <= r_out_col + 1'b1;
            end
            if (w_last_pix) r_last_out <= 1'b1;
        end
    end

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_resp),
        .i_push_data (m_readdata),
        .i_pop       (w_pop),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    assign pix_valid = !w_fifo_empty;
    assign pix_data  = pix_valid ? w_fifo_head : '0;
    assign pix_sof   = pix_valid && (r_out_row == '0) && (r_out_col == '0);
    assign pix_eol   = pix_valid && (r_out_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: tb/tb_pixel_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scanout
// Description : Self-checking bench for pixel_scanout on a 4x2 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scanout;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          D    = 4;
    localparam int          NPIX = H * V;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, frame_done;
    logic [31:0] m_address;
    logic        m_read;
    logic [15:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic        m_waitrequest = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof, pix_eol;

    pixel_scanout #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .frame_done(frame_done),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: counts of reads issued, responses returned, pixels delivered.
    int n_acc, n_resp, n_xfer, n_fd, n_sof, n_eol, n_stall, peak_inflight;
    int cyc = 0;
    int lat = 1;
    bit model_busy, prev_last;
    bit stall_en = 1'b0;
    int stall_cnt = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always @(negedge clk) begin
        if (reset) begin
            n_acc = 0; n_resp = 0; n_xfer = 0; n_fd = 0; n_sof = 0; n_eol = 0;
            n_stall = 0; peak_inflight = 0;
            model_busy = 1'b0; prev_last = 1'b0;
            q_addr.delete(); q_due.delete();
        end else begin
            bit acc, xfer, rsp;
            int inflight;
            logic [31:0] exp_addr;
            acc  = m_read && !m_waitrequest;
            xfer = pix_valid && pix_ready;
            rsp  = m_readdatavalid;
            chk("busy", 32'(busy), 32'(model_busy));
            chk("frame_done", 32'(frame_done), 32'(prev_last));
            chk("pix_valid", 32'(pix_valid), 32'(n_resp > n_xfer));
            if (m_read) chk("credit", 32'(n_acc - n_xfer < D), 32'd1);
            if (m_waitrequest) begin
                n_stall++;
                chk("stall_m_read", 32'(m_read), 32'd1);
                chk("stall_m_address", m_address, 32'h0800_0004);
            end
            inflight = n_acc + int'(acc) - n_resp;
            if (inflight > peak_inflight) peak_inflight = inflight;
            if (acc) begin
                exp_addr = BASE + 32'((n_acc / H) << 10) + 32'((n_acc % H) << 1);
                chk("m_address", m_address, exp_addr);
                if (n_acc == 2) chk("addr_pixel2", m_address, 32'h0800_0004);
                if (n_acc == 4) chk("addr_pixel4", m_address, 32'h0800_0400);
                q_addr.push_back(m_address);
                q_due.push_back(cyc + lat);
            end
            if (xfer) begin
                chk("pix_data", 32'(pix_data), 32'(n_xfer));
                chk("pix_sof", 32'(pix_sof), 32'(n_xfer == 0));
                chk("pix_eol", 32'(pix_eol), 32'(n_xfer % H == H - 1));
                n_sof += int'(pix_sof);
                n_eol += int'(pix_eol);
            end
            if (frame_done) n_fd++;
            if (frame_done) model_busy = 1'b0;
            else if (start && !model_busy) model_busy = 1'b1;
            prev_last = xfer && (n_xfer == NPIX - 1);
            n_acc  += int'(acc);
            n_resp += int'(rsp);
            n_xfer += int'(xfer);
        end
    end

    // Memory: halfword at each pixel address holds that pixel's frame index.
    always begin
        logic [31:0] off;
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            m_readdatavalid = 1'b0;
            m_readdata      = '0;
            m_waitrequest   = 1'b0;
        end else begin
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                off = q_addr[0] - BASE;
                m_readdata      = 16'((off >> 10) * H + ((off >> 1) & 32'h1FF));
                m_readdatavalid = 1'b1;
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata      = '0;
            end
            if (stall_en && stall_cnt < 5 &&
                (stall_cnt > 0 || (m_read && m_address == 32'h0800_0004))) begin
                m_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                m_waitrequest = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_m_read", 32'(m_read), 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_pix_sof", 32'(pix_sof), 32'd0);
        chk("rst_pix_eol", 32'(pix_eol), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = addr;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic end_frame();
        int n = 0;
        while (n_fd == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", 32'(n_fd != 0), 32'd1);
        repeat (6) @(negedge clk);
        chk("frame_done_count", 32'(n_fd), 32'd1);
        chk("pixels_delivered", 32'(n_xfer), 32'(NPIX));
        chk("reads_issued", 32'(n_acc), 32'(NPIX));
        chk("sof_count", 32'(n_sof), 32'd1);
        chk("eol_count", 32'(n_eol), 32'd2);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        // Basic frame, single-cycle read latency
        do_reset();
        pulse_start(BASE);
        end_frame();

        // Waitrequest held for 5 cycles on pixel 2
        do_reset();
        stall_cnt = 0;
        stall_en = 1'b1;
        pulse_start(BASE);
        end_frame();
        chk("stall_cycles", 32'(n_stall), 32'd5);
        stall_en = 1'b0;

        // Output backpressure for 40 cycles
        do_reset();
        pix_ready = 1'b0;
        pulse_start(BASE);
        repeat (40) @(negedge clk);
        chk("credits_used", 32'(n_acc), 32'd4);
        chk("read_held_off", 32'(m_read), 32'd0);
        chk("head_pixel_waiting", 32'(pix_data), 32'd0);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        end_frame();

        // Pipelined responses, latency 3
        lat = 3;
        do_reset();
        pulse_start(BASE);
        end_frame();
        chk("peak_inflight", 32'(peak_inflight), 32'd4);
        lat = 1;

        // Reset mid-frame after pixel 3, then restart
        do_reset();
        pulse_start(BASE);
        n = 0;
        while (n_xfer < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midframe_progress", 32'(n_xfer >= 4), 32'd1);
        do_reset();
        pulse_start(BASE);
        n = 0;
        while (!m_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("restart_address", m_address, 32'h0800_0000);
        end_frame();

        // Start while busy is ignored
        do_reset();
        pulse_start(BASE);
        repeat (2) @(posedge clk);
        pulse_start(32'h1000_0000);
        end_frame();
        repeat (10) @(negedge clk);
        chk("single_frame_done", 32'(n_fd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
